mem_bus_arb: RTL and testbench
==============================

Name: mem_bus_arb

Overview:
Two-master bus arbiter and access sequencer between the CPU pipeline and the single shared memory bus. It accepts instruction-fetch requests from the IF stage and load/store requests from the MEM-stage memory controller, grants one at a time, and drives the bus with an as_/rdy_ handshake. It returns read data and per-requester stall signals, and flags accesses that time out.

Parameters:
TIMEOUT, 15, maximum WAIT-state cycles before an access is aborted with bus_err.
CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high
if_req  input  1  IF fetch request, held until if_stall is low
if_addr  input  30  IF word address
if_rd_data  output  32  fetched word, valid in the cycle if_stall drops
if_stall  output  1  IF must hold its request
mem_as_  input  1  MEM-stage access strobe, active-low, from the memory controller
mem_rw  input  1  READ=1 / WRITE=0, same encoding as the memory controller
mem_addr  input  30  MEM word address
mem_wr_data  input  32  store data
mem_rd_data  output  32  load data, valid in the cycle mem_stall drops
mem_stall  output  1  MEM stage must hold its request
bus_as_  output  1  bus address strobe, active-low
bus_rw  output  1  bus direction
bus_addr  output  30  bus word address
bus_wr_data  output  32  bus write data
bus_rd_data  input  32  bus read data
bus_rdy_  input  1  slave ready, active-low
bus_err  output  1  one-cycle pulse: access timed out

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: state=IDLE, bus_as_=1, bus_rw=READ, bus_addr=0, bus_wr_data=0, if_rd_data=0, mem_rd_data=0, bus_err=0, counter=0, grant=NONE.
- Reset takes effect at the next clk edge from any state. An in-flight access is abandoned and bus_as_ is high in the following cycle.
- States:
  - IDLE: if mem_as_=0, grant=MEM. Latch mem_addr, mem_rw and mem_wr_data into the bus registers. Go to ACCESS.
  - IDLE, else if if_req=1: grant=IF. Latch if_addr and rw=READ. Go to ACCESS.
  - IDLE, else: stay in IDLE.
  - Priority is fixed: MEM over IF. The older instruction wins, so the pipeline cannot deadlock.
  - ACCESS: bus_as_=0 for exactly this cycle. If bus_rdy_=0, register bus_rd_data into the granted requester's rd_data and go to DONE. Otherwise clear the counter and go to WAIT.
  - WAIT: bus_as_=1. Address, rw and data registers are held stable.
  - WAIT, on bus_rdy_=0: capture the data as in ACCESS and go to DONE.
  - WAIT, when counter==TIMEOUT and bus_rdy_ is still 1: pulse bus_err, capture nothing, go to DONE.
  - WAIT, otherwise: counter+1.
  - DONE: release the granted requester for one cycle, then return to IDLE. Re-arbitration starts in IDLE of the next cycle, so back-to-back accesses are spaced 3 cycles apart.
- Stalls are combinational:
  - mem_stall = (mem_as_==0) and not (state==DONE and grant==MEM).
  - if_stall = if_req and not (state==DONE and grant==IF).
- Zero-wait latency: request seen in IDLE (cycle 0), bus_as_ low in cycle 1, stall low with data valid in cycle 2.
- Write accesses leave the rd_data outputs unchanged.
- A request withdrawn mid-access (pipeline flush) does not abort the bus cycle. The access completes; the result is captured but never consumed.
- Simultaneous requests in IDLE: MEM is granted and IF stays stalled. IF is granted at the next IDLE if MEM has dropped its request.
- Counter saturates at TIMEOUT and never wraps.
- bus_rdy_ seen in IDLE or DONE is ignored.

Decomposition:
- Shared header (alongside the existing CPU/bus headers):
  - state encodings BUS_ST_IDLE/ACCESS/WAIT/DONE (2 bits);
  - grant encodings GRANT_NONE/IF/MEM;
  - READ/WRITE and ENABLE_/DISABLE_ reuse the existing definitions.
- One natural sub-module: mem_bus_wdt. It contains the wait counter, with clear/enable inputs and a timeout output.

Test Plan:
- IF only, if_addr=30'h100, bus_rdy_ low when bus_as_ is low, bus_rd_data=32'hDEADBEEF -> bus_as_ low in cycle 1; if_stall low and if_rd_data=32'hDEADBEEF in cycle 2.
- Simultaneous if_req and mem_as_=0 store to 30'h20 with data 32'h12345678 -> MEM granted first: bus_rw=WRITE, bus_wr_data=32'h12345678. IF access starts at the next IDLE and completes 3 cycles later.
- MEM load with bus_rdy_ asserted after 4 WAIT cycles, data 32'hA5A5A5A5 -> mem_stall high for 6 cycles; mem_rd_data=32'hA5A5A5A5 in the 7th; addr held stable throughout.
- bus_rdy_ never asserted -> bus_err pulses once after TIMEOUT=15 WAIT cycles; mem_rd_data unchanged; FSM returns to IDLE.
- reset asserted during WAIT -> next cycle state IDLE, bus_as_=1, both stalls track raw requests, no bus_err.
- if_req dropped during WAIT -> access completes, then IDLE; no spurious grant afterwards.

Source files
------------

// File: rtl/mem_bus_arb_pkg.sv
// Shared encodings for the memory bus arbiter: FSM states, grant owner and
// the active-low strobe / bus direction constants used by the CPU bus.
package mem_bus_arb_pkg;

   localparam int unsigned ADDR_W = 30;
   localparam int unsigned DATA_W = 32;

   localparam logic READ     = 1'b1;
   localparam logic WRITE    = 1'b0;
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   typedef enum logic [1:0] {
      BUS_ST_IDLE   = 2'd0,
      BUS_ST_ACCESS = 2'd1,
      BUS_ST_WAIT   = 2'd2,
      BUS_ST_DONE   = 2'd3
   } bus_st_e;

   typedef enum logic [1:0] {
      GRANT_NONE = 2'd0,
      GRANT_IF   = 2'd1,
      GRANT_MEM  = 2'd2
   } grant_e;

endpackage

// File: rtl/mem_bus_arb_if.sv
// Requester-side and bus-side signals of the arbiter. The arbiter uses the
// master view; the surrounding pipeline/slave environment uses the slave view.
interface mem_bus_arb_if;
   import mem_bus_arb_pkg::*;

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rd_data;
   logic              if_stall;
   logic              mem_as_;
   logic              mem_rw;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wr_data;
   logic [DATA_W-1:0] mem_rd_data;
   logic              mem_stall;
   logic              bus_as_;
   logic              bus_rw;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wr_data;
   logic [DATA_W-1:0] bus_rd_data;
   logic              bus_rdy_;
   logic              bus_err;

   modport master (
      input  if_req, if_addr, mem_as_, mem_rw, mem_addr, mem_wr_data, bus_rd_data, bus_rdy_,
      output if_rd_data, if_stall, mem_rd_data, mem_stall,
      output bus_as_, bus_rw, bus_addr, bus_wr_data, bus_err
   );

   modport slave (
      output if_req, if_addr, mem_as_, mem_rw, mem_addr, mem_wr_data, bus_rd_data, bus_rdy_,
      input  if_rd_data, if_stall, mem_rd_data, mem_stall,
      input  bus_as_, bus_rw, bus_addr, bus_wr_data, bus_err
   );

endinterface

// File: rtl/mem_bus_wdt.sv
// Wait-state watchdog: counts WAIT cycles, saturating at TIMEOUT (never wraps).
module mem_bus_wdt #(
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned CNT_W   = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic timeout_o
);

   localparam logic [CNT_W-1:0] Limit = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != Limit)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout_o = (cnt_q == Limit);

endmodule

// File: rtl/mem_bus_arb.sv
// Two-master bus arbiter: MEM load/store has fixed priority over IF fetch.
// One access at a time over an as_/rdy_ handshake, aborted by a wait watchdog.
module mem_bus_arb #(
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned CNT_W   = 4
) (
   input logic           clk,
   input logic           reset,
   mem_bus_arb_if.master bus
);
   import mem_bus_arb_pkg::*;

   bus_st_e           state_q, state_d;
   grant_e            grant_q, grant_d;
   logic              bus_as_q, bus_as_d;
   logic              bus_rw_q, bus_rw_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0] bus_wr_data_q, bus_wr_data_d;
   logic [DATA_W-1:0] if_rd_data_q, if_rd_data_d;
   logic [DATA_W-1:0] mem_rd_data_q, mem_rd_data_d;
   logic              bus_err_q, bus_err_d;
   logic              rdy_seen, wdt_clr, wdt_en, wdt_timeout, timed_out;

   mem_bus_wdt #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_wdt (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (wdt_clr),
      .en_i      (wdt_en),
      .timeout_o (wdt_timeout)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= BUS_ST_IDLE;
         grant_q       <= GRANT_NONE;
         bus_as_q      <= DISABLE_;
         bus_rw_q      <= READ;
         bus_addr_q    <= '0;
         bus_wr_data_q <= '0;
         if_rd_data_q  <= '0;
         mem_rd_data_q <= '0;
         bus_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         bus_as_q      <= bus_as_d;
         bus_rw_q      <= bus_rw_d;
         bus_addr_q    <= bus_addr_d;
         bus_wr_data_q <= bus_wr_data_d;
         if_rd_data_q  <= if_rd_data_d;
         mem_rd_data_q <= mem_rd_data_d;
         bus_err_q     <= bus_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      unique case (state_q)
         BUS_ST_IDLE: begin
            if (bus.mem_as_ == ENABLE_) begin
               state_d = BUS_ST_ACCESS;
               grant_d = GRANT_MEM;
            end else if (bus.if_req) begin
               state_d = BUS_ST_ACCESS;
               grant_d = GRANT_IF;
            end
         end
         BUS_ST_ACCESS: state_d = rdy_seen ? BUS_ST_DONE : BUS_ST_WAIT;
         BUS_ST_WAIT: begin
            if (rdy_seen || timed_out) begin
               state_d = BUS_ST_DONE;
            end
         end
         BUS_ST_DONE: begin
            state_d = BUS_ST_IDLE;
            grant_d = GRANT_NONE;
         end
      endcase
   end

   // rdy_ only counts while a bus cycle is actually in flight
   always_comb begin
      rdy_seen      = ((state_q == BUS_ST_ACCESS) || (state_q == BUS_ST_WAIT)) &&
                      (bus.bus_rdy_ == ENABLE_);
      wdt_clr       = (state_q == BUS_ST_ACCESS);
      wdt_en        = (state_q == BUS_ST_WAIT);
      timed_out     = (state_q == BUS_ST_WAIT) && !rdy_seen && wdt_timeout;
      bus.mem_stall = (bus.mem_as_ == ENABLE_) &&
                      !((state_q == BUS_ST_DONE) && (grant_q == GRANT_MEM));
      bus.if_stall  = bus.if_req && !((state_q == BUS_ST_DONE) && (grant_q == GRANT_IF));
   end

   always_comb begin
      bus_as_d      = (state_d == BUS_ST_ACCESS) ? ENABLE_ : DISABLE_;
      bus_rw_d      = bus_rw_q;
      bus_addr_d    = bus_addr_q;
      bus_wr_data_d = bus_wr_data_q;
      if_rd_data_d  = if_rd_data_q;
      mem_rd_data_d = mem_rd_data_q;
      bus_err_d     = timed_out;
      if (state_q == BUS_ST_IDLE) begin
         if (grant_d == GRANT_MEM) begin
            bus_rw_d      = bus.mem_rw;
            bus_addr_d    = bus.mem_addr;
            bus_wr_data_d = bus.mem_wr_data;
         end else if (grant_d == GRANT_IF) begin
            bus_rw_d   = READ;
            bus_addr_d = bus.if_addr;
         end
      end
      // Writes complete without touching either rd_data register
      if (rdy_seen && (bus_rw_q == READ)) begin
         if (grant_q == GRANT_MEM) begin
            mem_rd_data_d = bus.bus_rd_data;
         end else if (grant_q == GRANT_IF) begin
            if_rd_data_d = bus.bus_rd_data;
         end
      end
   end

   assign bus.bus_as_     = bus_as_q;
   assign bus.bus_rw      = bus_rw_q;
   assign bus.bus_addr    = bus_addr_q;
   assign bus.bus_wr_data = bus_wr_data_q;
   assign bus.if_rd_data  = if_rd_data_q;
   assign bus.mem_rd_data = mem_rd_data_q;
   assign bus.bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_bus_arb.sv
// Bench for mem_bus_arb: directed scenarios plus a randomized transaction-level
// model in which each access takes 2 + min(latency, TIMEOUT + 1) cycles.
module tb_mem_bus_arb;

   localparam int unsigned TIMEOUT = 15;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   // Slave model: rdy_ low exactly slv_lat cycles after the strobe cycle
   bit          slv_act;
   int          slv_cnt;
   int          slv_lat;
   logic [31:0] slv_data;
   logic [31:0] exp_if_rd;
   logic [31:0] exp_mem_rd;

   mem_bus_arb_if bif ();

   mem_bus_arb #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      if (bif.bus_as_ == 1'b0) begin
         slv_act = 1'b1;
         slv_cnt = 0;
      end else if (slv_act) begin
         slv_cnt++;
         if (slv_cnt > 20) slv_act = 1'b0;
      end
      bif.bus_rdy_    = (slv_act && (slv_cnt == slv_lat)) ? 1'b0 : 1'b1;
      bif.bus_rd_data = slv_data;
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      bif.if_req  = 1'b0;
      bif.mem_as_ = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;
      checks++; if (bif.bus_as_ !== 1'b1) begin failures++;
         $display("FAIL reset_bus_as got=%b exp=1", bif.bus_as_); end
      checks++; if (bif.bus_rw !== 1'b1) begin failures++;
         $display("FAIL reset_bus_rw got=%b exp=1", bif.bus_rw); end
      checks++; if (bif.bus_addr !== 30'h0) begin failures++;
         $display("FAIL reset_bus_addr got=%h exp=0", bif.bus_addr); end
      checks++; if (bif.bus_wr_data !== 32'h0) begin failures++;
         $display("FAIL reset_bus_wr_data got=%h exp=0", bif.bus_wr_data); end
      checks++; if (bif.if_rd_data !== 32'h0 || bif.mem_rd_data !== 32'h0) begin failures++;
         $display("FAIL reset_rd_data got=%h/%h exp=0/0", bif.if_rd_data, bif.mem_rd_data); end
      checks++; if (bif.bus_err !== 1'b0) begin failures++;
         $display("FAIL reset_bus_err got=%b exp=0", bif.bus_err); end
      checks++; if (bif.if_stall !== 1'b0 || bif.mem_stall !== 1'b0) begin failures++;
         $display("FAIL reset_stalls got=%b/%b exp=0/0", bif.if_stall, bif.mem_stall); end
      exp_if_rd  = '0;
      exp_mem_rd = '0;
      // Raw requests raised and dropped within one idle cycle
      bif.if_req  = 1'b1;
      bif.mem_as_ = 1'b0;
      #1;
      checks++; if (bif.if_stall !== 1'b1 || bif.mem_stall !== 1'b1) begin failures++;
         $display("FAIL idle_stalls got=%b/%b exp=1/1", bif.if_stall, bif.mem_stall); end
      bif.if_req  = 1'b0;
      bif.mem_as_ = 1'b1;
      tick();
      #1;
      checks++; if (bif.bus_as_ !== 1'b1) begin failures++;
         $display("FAIL idle_no_grant bus_as_ got=%b exp=1", bif.bus_as_); end
   endtask

   task automatic test_if_fetch();
      tick();
      bif.if_req  = 1'b1;
      bif.if_addr = 30'h100;
      slv_lat     = 0;
      slv_data    = 32'hDEADBEEF;
      tick();
      #1;
      checks++; if (bif.bus_as_ !== 1'b0 || bif.bus_addr !== 30'h100) begin failures++;
         $display("FAIL fetch_c1 bus_as_/addr got=%b/%h exp=0/100", bif.bus_as_, bif.bus_addr); end
      checks++; if (bif.if_stall !== 1'b1) begin failures++;
         $display("FAIL fetch_c1 if_stall got=%b exp=1", bif.if_stall); end
      tick();
      #1;
      exp_if_rd = 32'hDEADBEEF;
      checks++; if (bif.if_stall !== 1'b0 || bif.if_rd_data !== exp_if_rd) begin failures++;
         $display("FAIL fetch_c2 stall/data got=%b/%h exp=0/%h",
                  bif.if_stall, bif.if_rd_data, exp_if_rd); end
      tick();
      bif.if_req = 1'b0;
   endtask

   task automatic test_simultaneous();
      tick();
      bif.if_req      = 1'b1;
      bif.if_addr     = 30'h3C;
      bif.mem_as_     = 1'b0;
      bif.mem_rw      = 1'b0;
      bif.mem_addr    = 30'h20;
      bif.mem_wr_data = 32'h12345678;
      slv_lat         = 0;
      slv_data        = 32'h0BADF00D;
      tick();
      #1;
      checks++; if (bif.bus_rw !== 1'b0 || bif.bus_addr !== 30'h20 ||
                    bif.bus_wr_data !== 32'h12345678) begin failures++;
         $display("FAIL simul_mem_first rw/addr/data got=%b/%h/%h exp=0/20/12345678",
                  bif.bus_rw, bif.bus_addr, bif.bus_wr_data); end
      tick();
      #1;
      checks++; if (bif.mem_stall !== 1'b0 || bif.if_stall !== 1'b1) begin failures++;
         $display("FAIL simul_mem_done stalls got=%b/%b exp=0/1", bif.mem_stall, bif.if_stall); end
      checks++; if (bif.mem_rd_data !== exp_mem_rd) begin failures++;
         $display("FAIL simul_write_rd got=%h exp=%h", bif.mem_rd_data, exp_mem_rd); end
      tick();
      bif.mem_as_ = 1'b1;
      tick();
      #1;
      checks++; if (bif.bus_as_ !== 1'b0 || bif.bus_addr !== 30'h3C || bif.bus_rw !== 1'b1) begin
         failures++;
         $display("FAIL simul_if_grant as_/addr/rw got=%b/%h/%b exp=0/3c/1",
                  bif.bus_as_, bif.bus_addr, bif.bus_rw); end
      tick();
      #1;
      exp_if_rd = 32'h0BADF00D;
      checks++; if (bif.if_stall !== 1'b0 || bif.if_rd_data !== exp_if_rd) begin failures++;
         $display("FAIL simul_if_done stall/data got=%b/%h exp=0/%h",
                  bif.if_stall, bif.if_rd_data, exp_if_rd); end
      tick();
      bif.if_req = 1'b0;
   endtask

   task automatic test_wait_load();
      logic [29:0] addr;
      addr = 30'($urandom);
      tick();
      bif.mem_as_  = 1'b0;
      bif.mem_rw   = 1'b1;
      bif.mem_addr = addr;
      slv_lat      = 4;
      slv_data     = 32'hA5A5A5A5;
      for (int k = 0; k <= 6; k++) begin
         if (k > 0) tick();
         #1;
         checks++; if (bif.mem_stall !== (k < 6)) begin failures++;
            $display("FAIL wait_stall k=%0d got=%b exp=%b", k, bif.mem_stall, k < 6); end
         if (k >= 1) begin
            checks++; if (bif.bus_addr !== addr || bif.bus_as_ !== (k != 1)) begin failures++;
               $display("FAIL wait_addr k=%0d addr/as_ got=%h/%b exp=%h/%b",
                        k, bif.bus_addr, bif.bus_as_, addr, k != 1); end
         end
      end
      exp_mem_rd = 32'hA5A5A5A5;
      checks++; if (bif.mem_rd_data !== exp_mem_rd || bif.bus_err !== 1'b0) begin failures++;
         $display("FAIL wait_data data/err got=%h/%b exp=%h/0",
                  bif.mem_rd_data, bif.bus_err, exp_mem_rd); end
      tick();
      bif.mem_as_ = 1'b1;
   endtask

   task automatic test_timeout();
      int err_cnt;
      err_cnt = 0;
      tick();
      bif.mem_as_  = 1'b0;
      bif.mem_rw   = 1'b1;
      bif.mem_addr = 30'h55;
      slv_lat      = 99;
      slv_data     = 32'hFEEDFACE;
      for (int k = 0; k <= 18; k++) begin
         if (k > 0) tick();
         #1;
         if (bif.bus_err === 1'b1) err_cnt++;
         checks++; if (bif.mem_stall !== (k < 18) || bif.bus_err !== (k == 18)) begin failures++;
            $display("FAIL timeout k=%0d stall/err got=%b/%b exp=%b/%b",
                     k, bif.mem_stall, bif.bus_err, k < 18, k == 18); end
      end
      checks++; if (bif.mem_rd_data !== exp_mem_rd) begin failures++;
         $display("FAIL timeout_rd got=%h exp=%h", bif.mem_rd_data, exp_mem_rd); end
      tick();
      bif.mem_as_ = 1'b1;
      #1;
      if (bif.bus_err === 1'b1) err_cnt++;
      checks++; if (err_cnt != 1) begin failures++;
         $display("FAIL timeout_pulses got=%0d exp=1", err_cnt); end
      tick();
      #1;
      checks++; if (bif.bus_as_ !== 1'b1 || bif.bus_err !== 1'b0) begin failures++;
         $display("FAIL timeout_idle as_/err got=%b/%b exp=1/0", bif.bus_as_, bif.bus_err); end
   endtask

   task automatic test_reset_in_wait();
      tick();
      bif.mem_as_  = 1'b0;
      bif.mem_rw   = 1'b1;
      bif.mem_addr = 30'h77;
      bif.if_req   = 1'b1;
      slv_lat      = 99;
      for (int k = 1; k <= 5; k++) tick();
      reset = 1'b1;
      tick();
      #1;
      exp_if_rd  = '0;
      exp_mem_rd = '0;
      checks++; if (bif.bus_as_ !== 1'b1 || bif.bus_err !== 1'b0) begin failures++;
         $display("FAIL rst_wait as_/err got=%b/%b exp=1/0", bif.bus_as_, bif.bus_err); end
      checks++; if (bif.mem_stall !== 1'b1 || bif.if_stall !== 1'b1) begin failures++;
         $display("FAIL rst_wait stalls got=%b/%b exp=1/1", bif.mem_stall, bif.if_stall); end
      checks++; if (bif.mem_rd_data !== exp_mem_rd || bif.bus_addr !== 30'h0) begin failures++;
         $display("FAIL rst_wait rd/addr got=%h/%h exp=0/0", bif.mem_rd_data, bif.bus_addr); end
      reset       = 1'b0;
      bif.mem_as_ = 1'b1;
      bif.if_req  = 1'b0;
      slv_act     = 1'b0;
      tick();
      #1;
      checks++; if (bif.bus_as_ !== 1'b1 || bif.mem_stall !== 1'b0 || bif.bus_err !== 1'b0) begin
         failures++;
         $display("FAIL rst_wait_after as_/stall/err got=%b/%b/%b exp=1/0/0",
                  bif.bus_as_, bif.mem_stall, bif.bus_err); end
   endtask

   task automatic test_flush();
      logic [31:0] data;
      data = $urandom;
      tick();
      bif.if_req  = 1'b1;
      bif.if_addr = 30'h1F0;
      slv_lat     = 6;
      slv_data    = data;
      for (int k = 0; k <= 12; k++) begin
         if (k > 0) tick();
         if (k == 3) bif.if_req = 1'b0;
         #1;
         if (k == 8) exp_if_rd = data;
         checks++; if (bif.bus_as_ !== (k != 1)) begin failures++;
            $display("FAIL flush_as k=%0d got=%b exp=%b", k, bif.bus_as_, k != 1); end
         if (k >= 3) begin
            checks++; if (bif.if_stall !== 1'b0 || bif.if_rd_data !== exp_if_rd) begin failures++;
               $display("FAIL flush k=%0d stall/data got=%b/%h exp=0/%h",
                        k, bif.if_stall, bif.if_rd_data, exp_if_rd); end
         end
      end
   endtask

   task automatic test_random();
      bit          pend_mem, pend_if, drop_mem, drop_if, m_rw, g_mem, tmo;
      logic [29:0] m_addr, i_addr;
      logic [31:0] m_wd;
      int          lat, done;
      pend_mem = 0; pend_if = 0; drop_mem = 0; drop_if = 0; m_rw = 1;
      m_addr = '0; i_addr = '0; m_wd = '0;
      for (int n = 0; n < 40; n++) begin
         tick();
         if (drop_mem) begin bif.mem_as_ = 1'b1; pend_mem = 0; end
         if (drop_if)  begin bif.if_req = 1'b0;  pend_if = 0;  end
         if (!pend_mem && !pend_if) begin
            case ($urandom_range(0, 2))
               0:       pend_mem = 1;
               1:       pend_if = 1;
               default: begin pend_mem = 1; pend_if = 1; end
            endcase
            m_rw   = 1'($urandom_range(0, 1));
            m_addr = 30'($urandom);
            m_wd   = $urandom;
            i_addr = 30'($urandom);
            bif.mem_as_     = !pend_mem;
            bif.mem_rw      = m_rw;
            bif.mem_addr    = m_addr;
            bif.mem_wr_data = m_wd;
            bif.if_req      = pend_if;
            bif.if_addr     = i_addr;
         end
         bif.bus_rdy_ = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 9))
            8:       lat = $urandom_range(15, 17);
            9:       lat = 40;
            default: lat = $urandom_range(0, 5);
         endcase
         slv_lat  = lat;
         slv_data = $urandom;
         g_mem    = pend_mem;
         tmo      = (lat > TIMEOUT + 1);
         done     = tmo ? TIMEOUT + 3 : 2 + lat;
         drop_mem = g_mem;
         drop_if  = !g_mem;
         for (int k = 0; k <= done; k++) begin
            if (k > 0) tick();
            if (k == done) begin
               bif.bus_rdy_ = 1'($urandom_range(0, 1));
               if (!tmo && g_mem && m_rw) exp_mem_rd = slv_data;
               if (!tmo && !g_mem) exp_if_rd = slv_data;
            end
            #1;
            checks++; if (bif.bus_as_ !== (k != 1) || bif.bus_err !== (k == done && tmo)) begin
               failures++;
               $display("FAIL rnd n=%0d k=%0d as_/err got=%b/%b exp=%b/%b",
                        n, k, bif.bus_as_, bif.bus_err, k != 1, k == done && tmo); end
            checks++; if (bif.mem_stall !== (pend_mem && !(k == done && g_mem)) ||
                          bif.if_stall !== (pend_if && !(k == done && !g_mem))) begin
               failures++;
               $display("FAIL rnd n=%0d k=%0d stalls got=%b/%b", n, k,
                        bif.mem_stall, bif.if_stall); end
            checks++; if (bif.mem_rd_data !== exp_mem_rd || bif.if_rd_data !== exp_if_rd) begin
               failures++;
               $display("FAIL rnd n=%0d k=%0d rd got=%h/%h exp=%h/%h", n, k,
                        bif.mem_rd_data, bif.if_rd_data, exp_mem_rd, exp_if_rd); end
            if (k >= 1) begin
               checks++; if (bif.bus_addr !== (g_mem ? m_addr : i_addr) ||
                             bif.bus_rw !== (g_mem ? m_rw : 1'b1) ||
                             (g_mem && !m_rw && bif.bus_wr_data !== m_wd)) begin
                  failures++;
                  $display("FAIL rnd n=%0d k=%0d addr/rw/wd got=%h/%b/%h", n, k,
                           bif.bus_addr, bif.bus_rw, bif.bus_wr_data); end
            end
         end
      end
      tick();
      bif.mem_as_  = 1'b1;
      bif.if_req   = 1'b0;
      bif.bus_rdy_ = 1'b1;
      tick();
   endtask

   initial begin
      clk             = 1'b0;
      reset           = 1'b1;
      checks          = 0;
      failures        = 0;
      slv_act         = 1'b0;
      slv_cnt         = 0;
      slv_lat         = 0;
      slv_data        = '0;
      exp_if_rd       = '0;
      exp_mem_rd      = '0;
      bif.if_req      = 1'b0;
      bif.if_addr     = '0;
      bif.mem_as_     = 1'b1;
      bif.mem_rw      = 1'b1;
      bif.mem_addr    = '0;
      bif.mem_wr_data = '0;
      bif.bus_rd_data = '0;
      bif.bus_rdy_    = 1'b1;
      test_reset();
      test_if_fetch();
      test_simultaneous();
      test_wait_load();
      test_timeout();
      test_reset_in_wait();
      test_flush();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
